prog_fetch: RTL and testbench

//   Program-counter / fetch sequencer that directly feeds the instruction decoder. Drives ProgCtr into

---
 rtl/prog_fetch_if.sv | 35 +++
 rtl/prog_fetch.sv | 115 +++++++++++
 tb/tb_prog_fetch.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/prog_fetch_if.sv
//==============================================================================
// Module : prog_fetch_if
// Brief  : Sequencer <-> decoder/ROM bundle for the program fetch sequencer.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

interface prog_fetch_if #(
    parameter int PC_W  = 10,
    parameter int CNT_W = 16
);
    logic             Start;
    logic             Stall;
    logic             Jen;
    logic             Taken;
    logic             Done;
    logic [PC_W-1:0]  Target;
    logic [PC_W-1:0]  ProgCtr;
    logic             InstValid;
    logic             Halted;
    logic [CNT_W-1:0] CycleCnt;
    logic [CNT_W-1:0] InstCnt;

    modport master (
        input  Start, Stall, Jen, Taken, Done, Target,
        output ProgCtr, InstValid, Halted, CycleCnt, InstCnt
    );

    modport slave (
        output Start, Stall, Jen, Taken, Done, Target,
        input  ProgCtr, InstValid, Halted, CycleCnt, InstCnt
    );
endinterface

`default_nettype wire

// File: rtl/prog_fetch.sv
//==============================================================================
// Module : prog_fetch
// Brief  : Program-counter / fetch sequencer with stall hold, branch and perf counters.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module prog_fetch #(
    parameter int PC_W      = 10,
    parameter int STALL_CYC = 1,
    parameter int CNT_W     = 16
) (
    input  logic          Clk,
    input  logic          Reset,
    prog_fetch_if.master  bus
);

    localparam int   HC_W        = (STALL_CYC < 1) ? 1 : $clog2(STALL_CYC + 1);
    localparam logic STALL_EN    = (STALL_CYC > 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HOLD = 2'd2,
        S_HALT = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [PC_W-1:0]  pend_q, pend_d;
    logic [HC_W-1:0]  hold_q, hold_d;
    logic [CNT_W-1:0] cyc_q, cyc_d;
    logic [CNT_W-1:0] inst_q, inst_d;

    logic [PC_W-1:0]  nxt_pc;
    logic [CNT_W-1:0] cyc_inc;
    logic [CNT_W-1:0] inst_inc;

    assign nxt_pc   = (bus.Jen && bus.Taken) ? bus.Target : pc_q + PC_W'(1);
    assign cyc_inc  = (cyc_q  == '1) ? cyc_q  : cyc_q  + CNT_W'(1);
    assign inst_inc = (inst_q == '1) ? inst_q : inst_q + CNT_W'(1);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            pend_q  <= '0;
            hold_q  <= '0;
            cyc_q   <= '0;
            inst_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            pend_q  <= pend_d;
            hold_q  <= hold_d;
            cyc_q   <= cyc_d;
            inst_q  <= inst_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        pend_d  = pend_q;
        hold_d  = hold_q;
        cyc_d   = cyc_q;
        inst_d  = inst_q;

        if (bus.Start) begin
            state_d = S_RUN;
            pc_d    = '0;
            hold_d  = '0;
            cyc_d   = '0;
            inst_d  = '0;
        end else begin
            case (state_q)
                S_RUN: begin
                    cyc_d = cyc_inc;
                    // Halt wins over stall: the halt retires immediately, no hold.
                    if (bus.Done) begin
                        state_d = S_HALT;
                        inst_d  = inst_inc;
                    end else if (bus.Stall && STALL_EN) begin
                        state_d = S_HOLD;
                        pend_d  = nxt_pc;
                        hold_d  = HC_W'(STALL_CYC);
                    end else begin
                        pc_d   = nxt_pc;
                        inst_d = inst_inc;
                    end
                end
                S_HOLD: begin
                    cyc_d = cyc_inc;
                    if (hold_q == HC_W'(1)) begin
                        state_d = S_RUN;
                        pc_d    = pend_q;
                        inst_d  = inst_inc;
                    end else begin
                        hold_d = hold_q - HC_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.ProgCtr   = pc_q;
    assign bus.InstValid = (state_q == S_RUN);
    assign bus.Halted    = (state_q == S_HALT);
    assign bus.CycleCnt  = cyc_q;
    assign bus.InstCnt   = inst_q;

endmodule

`default_nettype wire

// File: tb/tb_prog_fetch.sv
//==============================================================================
// Module : tb_prog_fetch
// Brief  : Scoreboard bench for prog_fetch: reference model predicts every cycle.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module tb_prog_fetch;

    localparam int PC_W      = 10;
    localparam int STALL_CYC = 1;
    localparam int CNT_W     = 16;
    localparam int OUT_W     = PC_W + 2 + 2 * CNT_W;

    localparam int M_IDLE = 0, M_RUN = 1, M_HOLD = 2, M_HALT = 3;

    logic Clk = 1'b0;
    logic Reset;

    prog_fetch_if #(.PC_W(PC_W), .CNT_W(CNT_W)) bus ();

    prog_fetch #(.PC_W(PC_W), .STALL_CYC(STALL_CYC), .CNT_W(CNT_W)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [OUT_W-1:0] sb[$];

    int m_st = M_IDLE, m_pc = 0, m_pend = 0, m_hold = 0, m_cyc = 0, m_inst = 0;

    // Stimulus word: {rst, start, stall, jen, taken, done, target[9:0]}
    function automatic logic [15:0] mk(bit r, bit s, bit st, bit j, bit t, bit d, int tgt);
        logic [9:0] tg;
        tg = tgt[9:0];
        return {r, s, st, j, t, d, tg};
    endfunction

    function automatic logic [OUT_W-1:0] dut_out();
        return {bus.ProgCtr, bus.InstValid, bus.Halted, bus.CycleCnt, bus.InstCnt};
    endfunction

    function automatic int sat(int v);
        return (v == (1 << CNT_W) - 1) ? v : v + 1;
    endfunction

    task automatic drive(input logic [15:0] w);
        int nxt;
        logic [PC_W-1:0] pcv;
        logic [CNT_W-1:0] cv, iv;
        @(negedge Clk);
        Reset      = w[15];
        bus.Start  = w[14];
        bus.Stall  = w[13];
        bus.Jen    = w[12];
        bus.Taken  = w[11];
        bus.Done   = w[10];
        bus.Target = w[9:0];
        if (w[15]) begin
            m_st = M_IDLE; m_pc = 0; m_pend = 0; m_hold = 0; m_cyc = 0; m_inst = 0;
        end else if (w[14]) begin
            m_st = M_RUN; m_pc = 0; m_hold = 0; m_cyc = 0; m_inst = 0;
        end else if (m_st == M_RUN) begin
            nxt   = (w[12] && w[11]) ? int'(w[9:0]) : (m_pc + 1) % (1 << PC_W);
            m_cyc = sat(m_cyc);
            if (w[10]) begin
                m_st = M_HALT; m_inst = sat(m_inst);
            end else if (w[13] && STALL_CYC > 0) begin
                m_st = M_HOLD; m_pend = nxt; m_hold = STALL_CYC;
            end else begin
                m_pc = nxt; m_inst = sat(m_inst);
            end
        end else if (m_st == M_HOLD) begin
            m_cyc = sat(m_cyc);
            if (m_hold == 1) begin
                m_st = M_RUN; m_pc = m_pend; m_inst = sat(m_inst);
            end else begin
                m_hold = m_hold - 1;
            end
        end
        pcv = m_pc[PC_W-1:0];
        cv  = m_cyc[CNT_W-1:0];
        iv  = m_inst[CNT_W-1:0];
        sb.push_back({pcv, (m_st == M_RUN), (m_st == M_HALT), cv, iv});
    endtask

    localparam logic [15:0] P   = 16'h0000;
    localparam logic [15:0] STA = 16'h4000;
    localparam logic [15:0] RST = 16'h8000;
    localparam logic [15:0] DN  = 16'h0400;

    task automatic test_reset();
        logic [15:0] seq[$];
        logic [OUT_W-1:0] got, exp;
        seq = {RST, mk(1, 1, 1, 1, 1, 1, 77), RST, P, P};
        foreach (seq[i]) begin
            drive(seq[i]);
            @(posedge Clk); #1;
            got = dut_out(); exp = sb.pop_front();
            n_checks++;
            if (got !== exp) begin
                n_errors++;
                $display("FAIL reset[%0d]: got %h expected %h", i, got, exp);
            end
        end
        n_checks++;
        if (bus.ProgCtr !== 10'd0 || bus.InstValid !== 1'b0 || bus.Halted !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_idle: got pc=%0d v=%b h=%b expected 0/0/0", bus.ProgCtr, bus.InstValid, bus.Halted);
        end
    endtask

    task automatic test_basic();
        logic [15:0] seq[$];
        logic [OUT_W-1:0] got, exp;
        seq = {STA, P, P, P, P, DN, mk(0, 0, 1, 1, 1, 0, 40), mk(0, 0, 0, 0, 0, 1, 3)};
        foreach (seq[i]) begin
            drive(seq[i]);
            @(posedge Clk); #1;
            got = dut_out(); exp = sb.pop_front();
            n_checks++;
            if (got !== exp) begin
                n_errors++;
                $display("FAIL basic[%0d]: got %h expected %h", i, got, exp);
            end
            if (i == 5) begin
                n_checks++;
                if (bus.Halted !== 1'b1 || bus.InstCnt !== 16'd5 || bus.CycleCnt !== 16'd5 || bus.ProgCtr !== 10'd4) begin
                    n_errors++;
                    $display("FAIL basic_halt: got h=%b inst=%0d cyc=%0d pc=%0d expected 1/5/5/4",
                             bus.Halted, bus.InstCnt, bus.CycleCnt, bus.ProgCtr);
                end
            end
        end
    endtask

    task automatic test_stall();
        logic [15:0] seq[$];
        logic [OUT_W-1:0] got, exp;
        seq = {STA, P, P, mk(0, 0, 1, 0, 0, 0, 0), mk(0, 0, 1, 1, 1, 1, 9), P, DN};
        foreach (seq[i]) begin
            drive(seq[i]);
            @(posedge Clk); #1;
            got = dut_out(); exp = sb.pop_front();
            n_checks++;
            if (got !== exp) begin
                n_errors++;
                $display("FAIL stall[%0d]: got %h expected %h", i, got, exp);
            end
            if (i == 3) begin
                n_checks++;
                if (bus.ProgCtr !== 10'd2 || bus.InstValid !== 1'b0) begin
                    n_errors++;
                    $display("FAIL stall_hold: got pc=%0d v=%b expected 2/0", bus.ProgCtr, bus.InstValid);
                end
            end
        end
        n_checks++;
        if (bus.CycleCnt !== 16'd6 || bus.InstCnt !== 16'd5) begin
            n_errors++;
            $display("FAIL stall_counts: got cyc=%0d inst=%0d expected 6/5", bus.CycleCnt, bus.InstCnt);
        end
    endtask

    task automatic test_branch();
        logic [15:0] seq[$];
        logic [OUT_W-1:0] got, exp;
        int exp_pc[3] = '{40, 6, 6};
        for (int k = 0; k < 3; k++) begin
            seq = {STA, P, P, P, P, P, mk(0, 0, 0, (k != 2), (k != 1), 0, 40)};
            foreach (seq[i]) begin
                drive(seq[i]);
                @(posedge Clk); #1;
                got = dut_out(); exp = sb.pop_front();
                n_checks++;
                if (got !== exp) begin
                    n_errors++;
                    $display("FAIL branch%0d[%0d]: got %h expected %h", k, i, got, exp);
                end
            end
            n_checks++;
            if (int'(bus.ProgCtr) !== exp_pc[k]) begin
                n_errors++;
                $display("FAIL branch_target%0d: got pc=%0d expected %0d", k, bus.ProgCtr, exp_pc[k]);
            end
        end
    endtask

    task automatic test_wrap_done_stall();
        logic [15:0] seq[$];
        logic [OUT_W-1:0] got, exp;
        seq = {STA, mk(0, 0, 0, 1, 1, 0, 1023), P, mk(0, 0, 0, 1, 1, 0, 7),
               mk(0, 0, 1, 0, 0, 1, 0), P};
        foreach (seq[i]) begin
            drive(seq[i]);
            @(posedge Clk); #1;
            got = dut_out(); exp = sb.pop_front();
            n_checks++;
            if (got !== exp) begin
                n_errors++;
                $display("FAIL wrap[%0d]: got %h expected %h", i, got, exp);
            end
            if (i == 2) begin
                n_checks++;
                if (bus.ProgCtr !== 10'd0) begin
                    n_errors++;
                    $display("FAIL wrap_pc: got pc=%0d expected 0", bus.ProgCtr);
                end
            end
            if (i == 4) begin
                n_checks++;
                if (bus.Halted !== 1'b1 || bus.ProgCtr !== 10'd7) begin
                    n_errors++;
                    $display("FAIL done_over_stall: got h=%b pc=%0d expected 1/7", bus.Halted, bus.ProgCtr);
                end
            end
        end
    endtask

    task automatic test_stall_branch();
        logic [15:0] seq[$];
        logic [OUT_W-1:0] got, exp;
        seq = {STA, mk(0, 0, 1, 1, 1, 0, 100), P, P};
        foreach (seq[i]) begin
            drive(seq[i]);
            @(posedge Clk); #1;
            got = dut_out(); exp = sb.pop_front();
            n_checks++;
            if (got !== exp) begin
                n_errors++;
                $display("FAIL stall_branch[%0d]: got %h expected %h", i, got, exp);
            end
            if (i == 2) begin
                n_checks++;
                if (bus.ProgCtr !== 10'd100 || bus.InstValid !== 1'b1) begin
                    n_errors++;
                    $display("FAIL stall_branch_pend: got pc=%0d v=%b expected 100/1", bus.ProgCtr, bus.InstValid);
                end
            end
        end
    endtask

    task automatic test_reset_in_hold();
        logic [15:0] seq[$];
        logic [OUT_W-1:0] got, exp;
        seq = {STA, P, mk(0, 0, 1, 0, 0, 0, 0), RST, P, P};
        foreach (seq[i]) begin
            drive(seq[i]);
            @(posedge Clk); #1;
            got = dut_out(); exp = sb.pop_front();
            n_checks++;
            if (got !== exp) begin
                n_errors++;
                $display("FAIL reset_hold[%0d]: got %h expected %h", i, got, exp);
            end
        end
        n_checks++;
        if (bus.ProgCtr !== 10'd0 || bus.CycleCnt !== 16'd0 || bus.InstCnt !== 16'd0 || bus.InstValid !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_hold_idle: got pc=%0d cyc=%0d inst=%0d v=%b expected 0/0/0/0",
                     bus.ProgCtr, bus.CycleCnt, bus.InstCnt, bus.InstValid);
        end
    endtask

    task automatic test_start_from_halt();
        logic [15:0] seq[$];
        logic [OUT_W-1:0] got, exp;
        seq = {STA, P, P, DN, P, STA, P, P, STA};
        foreach (seq[i]) begin
            drive(seq[i]);
            @(posedge Clk); #1;
            got = dut_out(); exp = sb.pop_front();
            n_checks++;
            if (got !== exp) begin
                n_errors++;
                $display("FAIL restart[%0d]: got %h expected %h", i, got, exp);
            end
            if (i == 5) begin
                n_checks++;
                if (bus.ProgCtr !== 10'd0 || bus.InstValid !== 1'b1 || bus.CycleCnt !== 16'd0 || bus.InstCnt !== 16'd0) begin
                    n_errors++;
                    $display("FAIL restart_clear: got pc=%0d v=%b cyc=%0d inst=%0d expected 0/1/0/0",
                             bus.ProgCtr, bus.InstValid, bus.CycleCnt, bus.InstCnt);
                end
            end
        end
    endtask

    initial begin
        Reset = 1'b1;
        bus.Start = 1'b0; bus.Stall = 1'b0; bus.Jen = 1'b0;
        bus.Taken = 1'b0; bus.Done = 1'b0; bus.Target = '0;
        test_reset();
        test_basic();
        test_stall();
        test_branch();
        test_wrap_done_stall();
        test_stall_branch();
        test_reset_in_hold();
        test_start_from_halt();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
